// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine: FSM state encoding and default address step.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_RD   = 3'd2,
      ST_RDW  = 3'd3,
      ST_WR   = 3'd4,
      ST_DONE = 3'd5
   } dma_state_t;

   localparam logic [31:0] ADDR_INC_DEFAULT = 32'd4;

endpackage

// File: rtl/dma_cnt32.sv
// 32-bit resettable counter: parallel load, or step up/down by a programmable amount.
module dma_cnt32 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        en,
   input  logic        dec,
   input  logic [31:0] step,
   output logic [31:0] q
);

   // Load has priority over stepping; arithmetic wraps modulo 2^32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         q <= 32'd0;
      else if (load)
         q <= load_val;
      else if (en)
         q <= dec ? (q - step) : (q + step);
   end

endmodule

// File: rtl/dma_engine.sv
// Single-channel memory-to-memory DMA: read one word, write one word, repeat.
module dma_engine
   import dma_pkg::*;
#(
   parameter logic [31:0] ADDR_INC = ADDR_INC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [31:0] size,
   input  logic        opclear,
   output logic        m_req,
   input  logic        m_grant,
   output logic [31:0] m_addr,
   output logic        m_wr,
   output logic [31:0] m_dout,
   input  logic [31:0] m_din,
   output logic        busy,
   output logic        done,
   output logic        interrupt
);

   dma_state_t  state;
   logic [31:0] src_q, dst_q, rem_q;
   logic [31:0] data_buf;
   logic        accept;
   logic        advance;

   // Descriptor is captured only when an idle engine accepts a non-empty job.
   assign accept  = (state == ST_IDLE) && start && (size != 32'd0);
   // Addresses and remaining count move together once the write is granted.
   assign advance = (state == ST_WR) && m_grant;

   dma_cnt32 u_src (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .load_val (src_addr),
      .en       (advance),
      .dec      (1'b0),
      .step     (ADDR_INC),
      .q        (src_q)
   );

   dma_cnt32 u_dst (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .load_val (dst_addr),
      .en       (advance),
      .dec      (1'b0),
      .step     (ADDR_INC),
      .q        (dst_q)
   );

   dma_cnt32 u_rem (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .load_val (size),
      .en       (advance),
      .dec      (1'b1),
      .step     (32'd1),
      .q        (rem_q)
   );

   // Bus address/data decode; read address is held through the data phase so a
   // stalled read keeps presenting the same location. Zero whenever idle on the bus.
   always_comb begin
      m_addr = 32'd0;
      m_dout = 32'd0;
      case (state)
         ST_RD, ST_RDW: m_addr = src_q;
         ST_WR: begin
            m_addr = dst_q;
            m_dout = data_buf;
         end
         default: ;
      endcase
   end

   // Sequencer: state, registered control outputs, data buffer and sticky interrupt.
   // A clear is overridden by any set in the same cycle (later assignment wins).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         m_req     <= 1'b0;
         m_wr      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         interrupt <= 1'b0;
         data_buf  <= 32'd0;
      end else begin
         if (opclear)
            interrupt <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (size == 32'd0) begin
                     state     <= ST_DONE;
                     done      <= 1'b1;
                     interrupt <= 1'b1;
                  end else begin
                     state <= ST_REQ;
                     m_req <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (m_grant)
                  state <= ST_RD;
            end
            ST_RD: begin
               if (m_grant)
                  state <= ST_RDW;
            end
            ST_RDW: begin
               if (m_grant) begin
                  data_buf <= m_din;
                  m_wr     <= 1'b1;
                  state    <= ST_WR;
               end
            end
            ST_WR: begin
               if (m_grant) begin
                  m_wr <= 1'b0;
                  if (rem_q == 32'd1) begin
                     state     <= ST_DONE;
                     m_req     <= 1'b0;
                     done      <= 1'b1;
                     interrupt <= 1'b1;
                  end else begin
                     state <= ST_RD;
                  end
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               interrupt <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
               m_req <= 1'b0;
               m_wr  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: bus memory model, write logger, scenario tasks.
module tb_dma_engine;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] src_addr, dst_addr, size;
   logic        opclear;
   logic        m_req;
   logic        m_grant;
   logic [31:0] m_addr;
   logic        m_wr;
   logic [31:0] m_dout;
   logic [31:0] m_din;
   logic        busy, done, interrupt;

   int checks = 0;
   int errors = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [31:0] rd_addr_q = 32'd0;
   int          req_seen = 0;
   int          done_cnt = 0;

   localparam int LIMIT = 200;

   dma_engine dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .size      (size),
      .opclear   (opclear),
      .m_req     (m_req),
      .m_grant   (m_grant),
      .m_addr    (m_addr),
      .m_wr      (m_wr),
      .m_dout    (m_dout),
      .m_din     (m_din),
      .busy      (busy),
      .done      (done),
      .interrupt (interrupt)
   );

   always #5 clk = ~clk;

   // Memory contents as a function of address.
   function automatic logic [31:0] pat(input logic [31:0] a);
      case (a)
         32'h0000_0100: pat = 32'hA5A5_A5A5;
         32'h0000_0104: pat = 32'h5A5A_5A5A;
         default:       pat = a ^ 32'hC3C3_0000;
      endcase
   endfunction

   // Read data follows the last granted read address by one cycle.
   assign m_din = pat(rd_addr_q);

   // Bus monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (m_req) req_seen++;
         if (done) done_cnt++;
         if (m_req && m_grant && m_wr) begin
            wr_addr.push_back(m_addr);
            wr_data.push_back(m_dout);
         end
         if (m_req && m_grant && !m_wr) rd_addr_q = m_addr;
         if (!m_req) begin
            checks++;
            if ({m_addr, m_dout} !== 64'd0) begin
               errors++;
               $display("FAIL idle_bus: addr=%h dout=%h expected 0", m_addr, m_dout);
            end
         end
      end
   end

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
      @(posedge clk); #1;
      src_addr = s; dst_addr = d; size = n; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      src_addr = 32'hDEAD_BEEF; dst_addr = 32'hDEAD_BEEF; size = 32'h0000_0007;
   endtask

   // Counts edges until done is seen; a timeout shows up as cnt == LIMIT.
   task automatic wait_done(output int cnt);
      cnt = 0;
      while (done !== 1'b1 && cnt < LIMIT) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic clear_irq;
      @(posedge clk); #1 opclear = 1'b1;
      @(posedge clk); #1 opclear = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (m_req !== 1'b0)      begin errors++; $display("FAIL rst_m_req: got %b expected 0", m_req); end
      checks++; if (m_wr !== 1'b0)       begin errors++; $display("FAIL rst_m_wr: got %b expected 0", m_wr); end
      checks++; if (m_addr !== 32'd0)    begin errors++; $display("FAIL rst_m_addr: got %h expected 0", m_addr); end
      checks++; if (m_dout !== 32'd0)    begin errors++; $display("FAIL rst_m_dout: got %h expected 0", m_dout); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
      checks++; if (interrupt !== 1'b0)  begin errors++; $display("FAIL rst_irq: got %b expected 0", interrupt); end
      @(posedge clk); #1 reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      int cnt;
      wr_addr.delete(); wr_data.delete();
      m_grant = 1'b1;
      pulse_start(32'h100, 32'h200, 32'd2);
      wait_done(cnt);
      checks++; if (cnt != 7) begin errors++; $display("FAIL basic_latency: got %0d expected 7", cnt); end
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_irq: got %b expected 1", interrupt); end
      checks++;
      if (wr_addr.size() != 2) begin
         errors++; $display("FAIL basic_wcount: got %0d expected 2", wr_addr.size());
      end else begin
         if (wr_addr[0] !== 32'h200 || wr_data[0] !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL basic_w0: got %h=%h expected 200=a5a5a5a5", wr_addr[0], wr_data[0]);
         end
         if (wr_addr[1] !== 32'h204 || wr_data[1] !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL basic_w1: got %h=%h expected 204=5a5a5a5a", wr_addr[1], wr_data[1]);
         end
      end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_size0;
      int cnt;
      clear_irq();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL z_irq_clr: got %b expected 0", interrupt); end
      req_seen = 0;
      pulse_start(32'h10, 32'h20, 32'd0);
      wait_done(cnt);
      // DONE is entered on the same edge that accepts start.
      checks++; if (cnt != 0) begin errors++; $display("FAIL z_latency: got %0d expected 0", cnt); end
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL z_irq: got %b expected 1", interrupt); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL z_done_pulse: got %b expected 0", done); end
      checks++; if (req_seen != 0) begin errors++; $display("FAIL z_no_req: got %0d expected 0", req_seen); end
   endtask

   task automatic test_grant_stall;
      int cnt;
      wr_addr.delete(); wr_data.delete();
      m_grant = 1'b1;
      pulse_start(32'h1000, 32'h2000, 32'd3);
      repeat (5) @(posedge clk);
      #1 m_grant = 1'b0;
      checks++; if (m_addr !== 32'h1004) begin errors++; $display("FAIL st_addr0: got %h expected 00001004", m_addr); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (m_addr !== 32'h1004 || m_wr !== 1'b0 || wr_addr.size() != 1) begin
            errors++; $display("FAIL st_frozen%0d: addr=%h wr=%b writes=%0d expected 00001004/0/1", i, m_addr, m_wr, wr_addr.size());
         end
      end
      m_grant = 1'b1;
      wait_done(cnt);
      checks++; if (cnt != 5) begin errors++; $display("FAIL st_resume: got %0d expected 5", cnt); end
      checks++;
      if (wr_addr.size() != 3) begin
         errors++; $display("FAIL st_wcount: got %0d expected 3", wr_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (wr_addr[i] !== 32'h2000 + 4*i || wr_data[i] !== pat(32'h1000 + 4*i)) begin
               errors++; $display("FAIL st_w%0d: got %h=%h expected %h=%h", i, wr_addr[i], wr_data[i],
                                  32'h2000 + 4*i, pat(32'h1000 + 4*i));
            end
         end
      end
      checks++; if (dut.u_rem.q !== 32'd0) begin errors++; $display("FAIL st_rem: got %h expected 0", dut.u_rem.q); end
   endtask

   task automatic test_wrap;
      int cnt;
      wr_addr.delete(); wr_data.delete();
      pulse_start(32'hFFFF_FFFC, 32'h300, 32'd2);
      repeat (4) @(posedge clk);
      #1;
      checks++; if (m_addr !== 32'd0 || m_req !== 1'b1) begin errors++; $display("FAIL wrap_rd2: addr=%h req=%b expected 00000000/1", m_addr, m_req); end
      wait_done(cnt);
      checks++;
      if (wr_addr.size() != 2) begin
         errors++; $display("FAIL wrap_wcount: got %0d expected 2", wr_addr.size());
      end else if (wr_addr[1] !== 32'h304 || wr_data[1] !== 32'hC3C3_0000 || wr_data[0] !== 32'h3C3C_FFFC) begin
         errors++; $display("FAIL wrap_data: got %h/%h@%h expected 3c3cfffc/c3c30000@304", wr_data[0], wr_data[1], wr_addr[1]);
      end
   endtask

   task automatic test_reset_mid;
      int cnt;
      clear_irq();
      pulse_start(32'h40, 32'h80, 32'd4);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (m_wr !== 1'b1) begin errors++; $display("FAIL rm_in_wr: got %b expected 1", m_wr); end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({m_req, m_wr, busy, done, interrupt} !== 5'd0 || m_addr !== 32'd0 || m_dout !== 32'd0) begin
         errors++; $display("FAIL rm_async: req=%b wr=%b busy=%b done=%b irq=%b addr=%h dout=%h expected all 0",
                            m_req, m_wr, busy, done, interrupt, m_addr, m_dout);
      end
      done_cnt = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (done_cnt != 0 || interrupt !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL rm_aborted: done=%0d irq=%b busy=%b expected 0/0/0", done_cnt, interrupt, busy);
      end
      wr_addr.delete(); wr_data.delete();
      pulse_start(32'h600, 32'h700, 32'd1);
      wait_done(cnt);
      checks++; if (cnt != 4) begin errors++; $display("FAIL rm_rerun_lat: got %0d expected 4", cnt); end
      checks++;
      if (wr_addr.size() != 1 || wr_addr[0] !== 32'h700 || wr_data[0] !== pat(32'h600)) begin
         errors++; $display("FAIL rm_rerun_w: writes=%0d expected 1 at 00000700=%h", wr_addr.size(), pat(32'h600));
      end
   endtask

   task automatic test_busy_start;
      int cnt;
      wr_addr.delete(); wr_data.delete();
      pulse_start(32'h400, 32'h500, 32'd2);
      repeat (2) @(posedge clk);
      #1;
      src_addr = 32'h900; dst_addr = 32'h900; size = 32'd1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(cnt);
      checks++; if (cnt != 4) begin errors++; $display("FAIL bs_latency: got %0d expected 4", cnt); end
      opclear = 1'b1;
      @(posedge clk); #1 opclear = 1'b0;
      checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL bs_set_wins: got %b expected 1", interrupt); end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || wr_addr.size() != 2) begin
         errors++; $display("FAIL bs_ignored: busy=%b writes=%0d expected 0/2", busy, wr_addr.size());
      end else if (wr_addr[0] !== 32'h500 || wr_addr[1] !== 32'h504) begin
         errors++; $display("FAIL bs_addrs: got %h,%h expected 00000500,00000504", wr_addr[0], wr_addr[1]);
      end
      clear_irq();
      checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL bs_clear: got %b expected 0", interrupt); end
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      opclear  = 1'b0;
      m_grant  = 1'b0;
      src_addr = 32'd0;
      dst_addr = 32'd0;
      size     = 32'd0;
      test_reset();
      test_basic();
      test_size0();
      test_grant_stall();
      test_wrap();
      test_reset_mid();
      test_busy_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
